// File: rtl/i2c_slave_rx_ctrl.sv
// Write-only I2C slave receive sequencer: matches a fixed 7-bit address, ACKs
// write bytes up to a per-transaction limit, and strobes each received byte out.
module i2c_slave_rx_ctrl #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h48,
  parameter int unsigned MAX_BYTES  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sda_in,
  input  logic       start_in,
  input  logic       stop_in,
  input  logic       scl_rise_in,
  input  logic       scl_fall_in,
  output logic       sda_pull_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  output logic       addr_hit_out,
  output logic [7:0] byte_cnt_out,
  output logic       busy_out
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BYTES);

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= 4'd0;
      shift        <= 8'h00;
      sda_pull_out <= 1'b0;
      rx_data_out  <= 8'h00;
      rx_valid_out <= 1'b0;
      addr_hit_out <= 1'b0;
      byte_cnt_out <= 8'h00;
      busy_out     <= 1'b0;
    end else begin
      rx_valid_out <= 1'b0;
      if (start_in) begin
        state        <= ADDR;
        bit_cnt      <= 4'd0;
        shift        <= 8'h00;
        sda_pull_out <= 1'b0;
        addr_hit_out <= 1'b0;
        byte_cnt_out <= 8'h00;
        busy_out     <= 1'b1;
      end else if (stop_in) begin
        state        <= IDLE;
        sda_pull_out <= 1'b0;
        addr_hit_out <= 1'b0;
        busy_out     <= 1'b0;
      end else begin
        case (state)
          ADDR, DATA: begin
            if (scl_rise_in) begin
              shift   <= {shift[6:0], sda_in};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall_in && bit_cnt == 4'd8) begin
              if (state == ADDR) begin
                // Only a write to our address is acknowledged; reads are ignored.
                if (shift[7:1] == SLAVE_ADDR && !shift[0]) begin
                  sda_pull_out <= 1'b1;
                  addr_hit_out <= 1'b1;
                  state        <= ADDR_ACK;
                end else begin
                  sda_pull_out <= 1'b0;
                  state        <= IGNORE;
                end
              end else begin
                // The byte is delivered even when it exceeds the limit and gets NACKed.
                rx_data_out  <= shift;
                rx_valid_out <= 1'b1;
                if (byte_cnt_out < MAX_CNT) begin
                  byte_cnt_out <= byte_cnt_out + 8'd1;
                  sda_pull_out <= 1'b1;
                  state        <= DATA_ACK;
                end else begin
                  sda_pull_out <= 1'b0;
                  state        <= IGNORE;
                end
              end
            end
          end
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall_in) begin
              sda_pull_out <= 1'b0;
              bit_cnt      <= 4'd0;
              state        <= DATA;
            end
          end
          IGNORE: begin
            sda_pull_out <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx_ctrl.sv
// Directed bench for i2c_slave_rx_ctrl: a transaction-level model tracks the
// expected outputs and a negedge process compares them every cycle.
module tb_i2c_slave_rx_ctrl;

  localparam logic [6:0] SLAVE = 7'h48;
  localparam int         MAXB  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sda_in = 1'b1;
  logic       start_in = 1'b0;
  logic       stop_in = 1'b0;
  logic       scl_rise_in = 1'b0;
  logic       scl_fall_in = 1'b0;
  logic       sda_pull_out;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       addr_hit_out;
  logic [7:0] byte_cnt_out;
  logic       busy_out;

  i2c_slave_rx_ctrl #(.SLAVE_ADDR(SLAVE), .MAX_BYTES(MAXB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sda_in(sda_in),
    .start_in(start_in),
    .stop_in(stop_in),
    .scl_rise_in(scl_rise_in),
    .scl_fall_in(scl_fall_in),
    .sda_pull_out(sda_pull_out),
    .rx_data_out(rx_data_out),
    .rx_valid_out(rx_valid_out),
    .addr_hit_out(addr_hit_out),
    .byte_cnt_out(byte_cnt_out),
    .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  typedef enum {P_IDLE, P_ADDR, P_DATA, P_IGNORE} phase_t;

  phase_t     phase = P_IDLE;
  logic       exp_pull = 1'b0;
  logic       exp_valid = 1'b0;
  logic       exp_hit = 1'b0;
  logic       exp_busy = 1'b0;
  logic [7:0] exp_data = 8'h00;
  int         exp_cnt = 0;
  logic       acked = 1'b0;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;
  int valid_count = 0;
  int pull_cycles = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle after reset release, all outputs must match the model.
  always @(negedge clk) begin
    if (checking) begin
      if (rx_valid_out === 1'b1) valid_count++;
      if (sda_pull_out === 1'b1) pull_cycles++;
      checkOutput("cycle",
        {12'b0, sda_pull_out, rx_data_out, rx_valid_out, addr_hit_out, byte_cnt_out, busy_out},
        {12'b0, exp_pull, exp_data, exp_valid, exp_hit, 8'(exp_cnt), exp_busy});
    end
  end

  // kind: 0 start, 1 stop, 2 scl rise, 3 scl fall; returns once the DUT has sampled it
  task automatic applyStimulus(input int kind);
    @(posedge clk); #1;
    exp_valid = 1'b0;
    case (kind)
      0: start_in = 1'b1;
      1: stop_in = 1'b1;
      2: scl_rise_in = 1'b1;
      default: scl_fall_in = 1'b1;
    endcase
    @(posedge clk); #1;
    start_in = 1'b0;
    stop_in = 1'b0;
    scl_rise_in = 1'b0;
    scl_fall_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      exp_valid = 1'b0;
    end
  endtask

  task automatic sendStart();
    applyStimulus(0);
    phase = P_ADDR;
    exp_pull = 1'b0;
    exp_hit = 1'b0;
    exp_cnt = 0;
    exp_busy = 1'b1;
    acked = 1'b0;
  endtask

  task automatic sendStop();
    applyStimulus(1);
    phase = P_IDLE;
    exp_pull = 1'b0;
    exp_hit = 1'b0;
    exp_busy = 1'b0;
    acked = 1'b0;
  endtask

  task automatic sendBits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_in = b[7-i];
      applyStimulus(2);
      applyStimulus(3);
    end
    if (n == 8) begin
      acked = 1'b0;
      if (phase == P_ADDR) begin
        if (b == {SLAVE, 1'b0}) begin
          exp_pull = 1'b1;
          exp_hit = 1'b1;
          acked = 1'b1;
          phase = P_DATA;
        end else begin
          phase = P_IGNORE;
        end
      end else if (phase == P_DATA) begin
        exp_data = b;
        exp_valid = 1'b1;
        if (exp_cnt < MAXB) begin
          exp_cnt++;
          exp_pull = 1'b1;
          acked = 1'b1;
        end else begin
          phase = P_IGNORE;
        end
      end
    end
  endtask

  task automatic ackSlot();
    sda_in = 1'b1;
    applyStimulus(2);
    applyStimulus(3);
    if (acked) begin
      exp_pull = 1'b0;
      acked = 1'b0;
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    sendBits(b, 8);
    ackSlot();
  endtask

  task automatic pulseReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    phase = P_IDLE;
    exp_pull = 1'b0;
    exp_hit = 1'b0;
    exp_busy = 1'b0;
    exp_data = 8'h00;
    exp_cnt = 0;
    acked = 1'b0;
  endtask

  task automatic clearCounters();
    valid_count = 0;
    pull_cycles = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checking = 1'b1;
    idle(2);
    checkOutput("reset_data", rx_data_out, 8'h00);
    checkOutput("reset_busy", busy_out, 1'b0);

    $display("[TB] single byte write");
    clearCounters();
    sendStart();
    sendByte(8'h90);
    sendByte(8'hA5);
    sendStop();
    idle(2);
    checkOutput("single_data", rx_data_out, 8'hA5);
    checkOutput("single_cnt", byte_cnt_out, 8'd1);
    checkOutput("single_busy", busy_out, 1'b0);
    checkOutput("single_valids", valid_count, 1);
    checkOutput("single_ack_cycles", pull_cycles, 8);

    $display("[TB] address mismatch");
    clearCounters();
    sendStart();
    sendByte(8'h92);
    sendByte(8'h11);
    sendStop();
    idle(2);
    checkOutput("mismatch_valids", valid_count, 0);
    checkOutput("mismatch_pulls", pull_cycles, 0);
    checkOutput("mismatch_cnt", byte_cnt_out, 8'd0);

    $display("[TB] read request");
    clearCounters();
    sendStart();
    sendByte(8'h91);
    sendByte(8'h55);
    checkOutput("read_busy", busy_out, 1'b1);
    checkOutput("read_hit", addr_hit_out, 1'b0);
    sendStop();
    idle(2);
    checkOutput("read_pulls", pull_cycles, 0);
    checkOutput("read_valids", valid_count, 0);

    $display("[TB] repeated start mid data");
    clearCounters();
    sendStart();
    sendByte(8'h90);
    sendByte(8'h3C);
    sendBits(8'hF0, 4);
    sendStart();
    sendByte(8'h90);
    sendByte(8'h7E);
    sendStop();
    idle(2);
    checkOutput("rstart_valids", valid_count, 2);
    checkOutput("rstart_cnt", byte_cnt_out, 8'd1);
    checkOutput("rstart_data", rx_data_out, 8'h7E);

    $display("[TB] byte limit overrun");
    clearCounters();
    sendStart();
    sendByte(8'h90);
    sendByte(8'h01);
    sendByte(8'h02);
    sendByte(8'h03);
    sendStop();
    idle(2);
    checkOutput("overrun_valids", valid_count, 3);
    checkOutput("overrun_cnt", byte_cnt_out, 8'd2);
    checkOutput("overrun_data", rx_data_out, 8'h03);
    checkOutput("overrun_ack_cycles", pull_cycles, 12);

    $display("[TB] reset during address ACK");
    sendStart();
    sendBits(8'h90, 8);
    checkOutput("ack_before_reset", sda_pull_out, 1'b1);
    pulseReset();
    checkOutput("reset_pull", sda_pull_out, 1'b0);
    checkOutput("reset_hit", addr_hit_out, 1'b0);
    checkOutput("reset_busy2", busy_out, 1'b0);
    idle(2);
    clearCounters();
    sendStart();
    sendByte(8'h90);
    sendByte(8'h5A);
    sendStop();
    idle(2);
    checkOutput("post_reset_data", rx_data_out, 8'h5A);
    checkOutput("post_reset_cnt", byte_cnt_out, 8'd1);
    checkOutput("post_reset_valids", valid_count, 1);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx_ctrl.md
Name: i2c_slave_rx_ctrl

Overview:
- Write-only I2C slave receive sequencer, placed directly after the I2C condition/edge detector in the filter's I2C path.
- Consumes single-cycle start/stop/SCL-edge strobes plus the filtered SDA level.
- Shifts in the address byte and compares it to a fixed slave address, ACKs a matching write, then deframes data bytes.
- Presents each data byte to the register-file side with a one-cycle valid strobe and drives the SDA pull-down for ACK slots.

Parameters:
- SLAVE_ADDR, 7'h48, 7-bit address this slave responds to.
- MAX_BYTES, 255, data bytes ACKed per transaction; byte MAX_BYTES+1 and later are NACKed.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; synchronous, active-low.
- sda_in  input  1  filtered SDA level.
- start_in  input  1  START/repeated-START strobe, 1 cycle.
- stop_in  input  1  STOP strobe, 1 cycle.
- scl_rise_in  input  1  SCL rising-edge strobe, 1 cycle.
- scl_fall_in  input  1  SCL falling-edge strobe, 1 cycle.
- sda_pull_out  input→output  1  1 = drive SDA low (ACK); 0 = release.
- rx_data_out  output  8  last received data byte.
- rx_valid_out  output  1  1-cycle strobe: rx_data_out updated.
- addr_hit_out  output  1  high while in an addressed write transaction.
- byte_cnt_out  output  8  data bytes ACKed in current transaction.
- busy_out  output  1  high from START until STOP.

(sda_pull_out is an output, 1 bit.)

Behaviour:
- All outputs registered.
- Reset value of every output: sda_pull_out=0, rx_data_out=8'h00, rx_valid_out=0, addr_hit_out=0, byte_cnt_out=0, busy_out=0.
- Internal reset values: state=IDLE, bit_cnt=0, shift=0.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- Priority every cycle: rst_n=0 > start_in > stop_in > scl edges.
- start_in (any state, including mid-byte or mid-ACK):
  - next state ADDR; bit_cnt=0, shift=0, sda_pull_out=0, addr_hit_out=0, byte_cnt_out=0, busy_out=1.
- stop_in (any state): next state IDLE; sda_pull_out=0, addr_hit_out=0, busy_out=0; byte_cnt_out and rx_data_out hold.
- Bit sampling (ADDR, DATA): on scl_rise_in, shift={shift[6:0],sda_in} (MSB first), bit_cnt++.
- ADDR, on scl_fall_in with bit_cnt==8:
  - if shift[7:1]==SLAVE_ADDR and shift[0]==0 (write): sda_pull_out=1, addr_hit_out=1, state ADDR_ACK.
  - otherwise (mismatch or read): state IGNORE, SDA released.
- ADDR_ACK, on scl_fall_in: sda_pull_out=0, bit_cnt=0, state DATA.
- DATA, on scl_fall_in with bit_cnt==8:
  - rx_data_out=shift, rx_valid_out=1 for exactly one cycle.
  - if byte_cnt_out<MAX_BYTES: byte_cnt_out++, sda_pull_out=1, state DATA_ACK.
  - else: no ACK, state IGNORE (byte still delivered).
- DATA_ACK, on scl_fall_in: sda_pull_out=0, bit_cnt=0, state DATA.
- IGNORE: SDA released; only start_in/stop_in leave.
- IDLE: scl edges ignored.
- Latency: registered outputs change on the clock edge that samples the strobe, so they are visible the cycle after the strobe is high.
- scl_fall_in with bit_cnt<8 in ADDR/DATA: no action.
- The detector guarantees start_in/stop_in are mutually exclusive and never coincide with scl edges; no further handling required.
- Reset mid-transaction: immediate return to IDLE with reset values, SDA released the next cycle.

Test Plan:
- Single byte write: START, addr 0x90 (7'h48+W), data 0xA5, STOP → ACK pulses after addr and data; rx_data_out=0xA5; one rx_valid_out pulse; byte_cnt_out=1; busy_out low after STOP.
- Address mismatch: START, 0x92, data 0x11, STOP → sda_pull_out never 1; no rx_valid_out; addr_hit_out stays 0.
- Read request: START, 0x91 → no ACK; state IGNORE until STOP.
- Repeated START mid-data: 0x90, 0x3C, then START after 4 bits, then 0x90, 0x7E, STOP → two valid pulses (0x3C, 0x7E); final byte_cnt_out=1.
- MAX_BYTES=2 overrun: write 0x01, 0x02, 0x03 → first two ACKed; third NACKed but strobed with rx_data_out=0x03; byte_cnt_out=2.
- Reset during ADDR_ACK (sda_pull_out=1), rst_n low 1 cycle → next cycle all outputs at reset values; following clean transaction works.
